// File: rtl/multiword_addsub_seq_pkg.sv
// Shared definitions for the multi-word add/subtract engine: FSM encoding,
// adder slice width and the slice-index width helper.
package multiword_addsub_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int SLICE_W = 8;

   // Bits needed to index NSLICES slices; never less than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multiword_addsub_seq_csa.sv
// 8-bit conditional-sum adder/subtractor. The upper half is computed for both
// possible carries and the lower-half carry selects between them.
// mode=1 subtracts by inverting y; the caller supplies cin=1 for the first slice.
module multiword_addsub_seq_csa
   import multiword_addsub_seq_pkg::*;
(
   input  logic [SLICE_W-1:0] x,
   input  logic [SLICE_W-1:0] y,
   input  logic               mode,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);

   localparam int HALF = SLICE_W / 2;

   logic [SLICE_W-1:0] w_y;
   logic [HALF:0]      w_lo;
   logic [HALF:0]      w_hi0;
   logic [HALF:0]      w_hi1;
   logic [HALF:0]      w_hi;

   assign w_y   = y ^ {SLICE_W{mode}};
   assign w_lo  = {1'b0, x[HALF-1:0]} + {1'b0, w_y[HALF-1:0]} + {{HALF{1'b0}}, cin};
   assign w_hi0 = {1'b0, x[SLICE_W-1:HALF]} + {1'b0, w_y[SLICE_W-1:HALF]};
   assign w_hi1 = {1'b0, x[SLICE_W-1:HALF]} + {1'b0, w_y[SLICE_W-1:HALF]} + {{HALF{1'b0}}, 1'b1};
   assign w_hi  = w_lo[HALF] ? w_hi1 : w_hi0;

   assign sum  = {w_hi[HALF-1:0], w_lo[HALF-1:0]};
   assign cout = w_hi[HALF];

endmodule

// File: rtl/multiword_addsub_seq.sv
// Sequential multi-word add/subtract engine. Wide operands pass through one
// 8-bit adder slice per cycle, LSB first, with the carry chained in a register.
// Requests and results use valid/ready handshakes; one operation in flight.
module multiword_addsub_seq
   import multiword_addsub_seq_pkg::*;
#(
   parameter  int NSLICES = 4,
   localparam int WIDTH   = SLICE_W * NSLICES
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int IDX_W = idx_w(NSLICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_sub;
   logic [IDX_W-1:0]   r_idx;
   logic               r_carry;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry_out;
   logic               r_overflow;
   logic               r_zero;

   logic [SLICE_W-1:0] w_x;
   logic [SLICE_W-1:0] w_y;
   logic [SLICE_W-1:0] w_sum;
   logic               w_cout;
   logic               w_last;
   logic               w_ovf;
   logic               w_zero;

   assign w_x    = r_a[r_idx*SLICE_W +: SLICE_W];
   assign w_y    = r_b[r_idx*SLICE_W +: SLICE_W];
   assign w_last = (r_idx == LAST_IDX);

   multiword_addsub_seq_csa u_csa (
      .x    (w_x),
      .y    (w_y),
      .mode (r_sub),
      .cin  (r_carry),
      .sum  (w_sum),
      .cout (w_cout)
   );

   // Flags for the final slice: overflow from operand/result sign bits, zero
   // from the already-written lower slices plus the slice being written now.
   assign w_ovf  = r_sub ? ((r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sum[SLICE_W-1] != r_a[WIDTH-1]))
                         : ((r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[SLICE_W-1] != r_a[WIDTH-1]));
   assign w_zero = (r_result[WIDTH-SLICE_W-1:0] == '0) && (w_sum == '0);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values, so process order never matters.
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next_state;
   end

   // Next-state and handshake outputs.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latches.
      w_next_state = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next_state = ST_RUN;
         end
         ST_RUN: begin
            if (w_last) w_next_state = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Operand capture, slice walk, result assembly and flag update.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: operand and result registers are reset as well, so an abort
      // leaves no stale state behind.
      if (!reset_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_sub       <= 1'b0;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
         r_zero      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_sub   <= sub;
                  r_idx   <= '0;
                  r_carry <= sub;
               end
            end
            ST_RUN: begin
               r_result[r_idx*SLICE_W +: SLICE_W] <= w_sum;
               r_carry <= w_cout;
               if (w_last) begin
                  r_carry_out <= w_cout;
                  r_overflow  <= w_ovf;
                  r_zero      <= w_zero;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign result    = r_result;
   assign carry_out = r_carry_out;
   assign overflow  = r_overflow;
   assign zero      = r_zero;

endmodule

// File: tb/tb_multiword_addsub_seq.sv
// Directed self-checking bench for multiword_addsub_seq (NSLICES=4, 32-bit).
module tb_multiword_addsub_seq;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        carry_out;
   logic        overflow;
   logic        zero;

   int vectors     = 0;
   int miscompares = 0;

   multiword_addsub_seq #(.NSLICES(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "/in_ready"},  {31'd0, in_ready},  32'd1);
      check({tag, "/out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "/result"},    result,             32'h0000_0000);
      check({tag, "/carry_out"}, {31'd0, carry_out}, 32'd0);
      check({tag, "/overflow"},  {31'd0, overflow},  32'd0);
      check({tag, "/zero"},      {31'd0, zero},      32'd0);
   endtask

   // Called just after the accept edge; counts edges until out_valid.
   task automatic wait_result(input string tag);
      int lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "/latency"}, lat, 32'd4);
   endtask

   task automatic check_outputs(input string tag, input logic [31:0] exp_r,
                                input logic exp_c, input logic exp_ov, input logic exp_z);
      check({tag, "/out_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "/result"},    result,             exp_r);
      check({tag, "/carry_out"}, {31'd0, carry_out}, {31'd0, exp_c});
      check({tag, "/overflow"},  {31'd0, overflow},  {31'd0, exp_ov});
      check({tag, "/zero"},      {31'd0, zero},      {31'd0, exp_z});
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "/drain_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "/drain_ready"}, {31'd0, in_ready},  32'd1);
   endtask

   task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic op_sub, input logic [31:0] exp_r,
                         input logic exp_c, input logic exp_ov, input logic exp_z);
      check({tag, "/idle_ready"}, {31'd0, in_ready}, 32'd1);
      a = op_a; b = op_b; sub = op_sub; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "/busy"}, {31'd0, in_ready}, 32'd0);
      wait_result(tag);
      check_outputs(tag, exp_r, exp_c, exp_ov, exp_z);
      release_result(tag);
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sub = 1'b0;

      // 1. Reset values, during and after reset.
      #12;
      check_reset_values("rst_hold");
      reset_n = 1'b1;
      tick();
      check_reset_values("rst_rel");

      // 2. Carry ripple across a slice boundary.
      run_op("add_ripple", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);

      // 3. Wrap to zero, then signed overflow.
      run_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      run_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

      // 4. Subtract with overflow, then with borrow.
      run_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

      // 5. Backpressure: result holds while inputs wiggle.
      a = 32'h0102_0304; b = 32'h1020_3040; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_result("bp");
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         a = $urandom;
         b = $urandom;
         sub = i[1];
         tick();
         check_outputs("bp_hold", 32'h1122_3344, 1'b0, 1'b0, 1'b0);
         check("bp_hold/in_ready", {31'd0, in_ready}, 32'd0);
      end
      a = 32'h0000_0002; b = 32'h0000_0003; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_drain/out_valid", {31'd0, out_valid}, 32'd0);
      check("bp_drain/in_ready",  {31'd0, in_ready},  32'd1);
      tick();
      in_valid = 1'b0;
      check("bp_next/accepted", {31'd0, in_ready}, 32'd0);
      wait_result("bp_next");
      check_outputs("bp_next", 32'h0000_0005, 1'b0, 1'b0, 1'b0);
      release_result("bp_next");

      // 6. Abort mid-RUN at slice index 2.
      a = 32'hAAAA_5555; b = 32'h0F0F_0F0F; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      check_reset_values("abort");
      #2;
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("abort/no_valid", {31'd0, out_valid}, 32'd0);
      end
      run_op("post_abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multiword_addsub_seq.md
Name: multiword_addsub_seq

Overview:
Sequential multi-word add/subtract engine that sends wide operands through the team's 8-bit conditional-sum adder/subtractor one byte slice per cycle, LSB slice first. The block chains the carry between slices in a register. It sits directly upstream of that adder: it drives x, y, mode and cin, and it consumes sum and cout. Operands arrive and results leave over valid/ready handshakes, so the block can sit between a register-file read stage and a writeback stage.

Parameters:
NSLICES, 4, number of 8-bit slices per operand; must be 2 or more.
WIDTH, 8*NSLICES, operand and result width; localparam, not overridable.

Ports:
clk  input  1  system clock, rising-edge active.
reset_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand request is valid.
in_ready  output  1  block can accept a request; high only in IDLE.
a  input  WIDTH  minuend or first addend.
b  input  WIDTH  subtrahend or second addend.
sub  input  1  0 = a+b, 1 = a-b (two's complement).
out_valid  output  1  result and flags are valid.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  registered sum or difference.
carry_out  output  1  final slice cout; for subtract, 1 = no borrow (a>=b unsigned).
overflow  output  1  signed two's-complement overflow.
zero  output  1  result == 0.

Behaviour:
- Reset and clocking: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, carry_out=0, overflow=0, zero=0, slice index=0, carry register=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a, b and sub; set slice index=0 and carry register=sub; go to RUN.
- RUN:
  - Each cycle, drive the adder combinationally with x=a_reg[idx*8+:8], y=b_reg[idx*8+:8], mode=sub_reg, cin=carry register.
  - At the clock edge, write result[idx*8+:8] with the adder sum and load the carry register with cout.
  - When idx==NSLICES-1, also update the flags and go to DONE; otherwise idx increments.
- DONE:
  - out_valid=1; result and flags hold stable.
  - On out_ready, clear out_valid and go to IDLE.
  - A request is never accepted in the same cycle as the result handshake, so throughput is one operation per NSLICES+2 cycles at best.
- Latency: out_valid rises on the NSLICES-th rising edge after the accept edge.
- in_ready is low in RUN and DONE. in_valid is ignored there, and a, b and sub may change without effect.
- Flags, computed from registered values at the final RUN edge:
  - carry_out = final cout.
  - Add overflow: a_msb==b_msb && r_msb!=a_msb.
  - Subtract overflow: a_msb!=b_msb && r_msb!=a_msb.
  - zero = full result (including the final slice) is all-zero.
- Result slices not yet written during RUN keep their previous values. They are not observable because out_valid=0.
- Reset asserted mid-operation (RUN or DONE) aborts immediately to reset values. No out_valid is ever produced for the aborted operation.
- Width rules: no width extension; the result wraps modulo 2^WIDTH.

Decomposition:
- Shared package: state encoding (IDLE/RUN/DONE), SLICE_W=8 constant, slice-index width function (clog2 of NSLICES).
- One sub-module: the existing 8-bit conditional-sum adder/subtractor, instantiated once. This block contains only the datapath registers and the FSM.

Test Plan:
1. Reset: hold reset_n low, then release -> in_ready=1, out_valid=0, result=0x00000000, all flags 0.
2. Add carry ripple: a=0x000000FF, b=0x00000001, sub=0 -> result=0x00000100, carry_out=0, overflow=0, zero=0. out_valid exactly 4 cycles after the accept edge.
3. Add wrap: a=0xFFFFFFFF, b=0x00000001, sub=0 -> result=0x00000000, carry_out=1, zero=1, overflow=0. Then a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1, carry_out=0.
4. Subtract: a=0x80000000, b=0x00000001, sub=1 -> result=0x7FFFFFFF, carry_out=1, overflow=1. Then a=5, b=7 -> result=0xFFFFFFFE, carry_out=0, overflow=0.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid, toggling in_valid, a and b -> result and flags stable, in_ready=0, no new accept. Raise out_ready -> IDLE next cycle; the next request is accepted one cycle later.
6. Abort: pulse reset_n low during the RUN cycle with idx=2 -> all outputs return to reset values at once; out_valid never asserts for that operation; a following request (0x12345678+0x11111111) returns 0x23456789.
